// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the five-stage pipeline hazard/stall controller.
package pipeline_pkg;

    localparam int unsigned MEM_TIMEOUT_DEF = 16;
    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned REG_IDX_W       = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    // Per-cycle pipeline register controls
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic pc_src;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE      = ctrl_t'(8'h00);
    localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(8'h01);

    // Decode used whenever data memory is not holding the pipeline
    function automatic ctrl_t decode_run(input logic branch_taken, input logic load_use);
        ctrl_t c;
        c = CTRL_IDLE;
        if (branch_taken) begin
            c.pc_write    = 1'b1;
            c.ifid_write  = 1'b1;
            c.idex_write  = 1'b1;
            c.exmem_write = 1'b1;
            c.pc_src      = 1'b1;
            c.ifid_flush  = 1'b1;
            c.idex_flush  = 1'b1;
        end else if (load_use) begin
            // PC and IF/ID hold; ID/EX captures a bubble; older stages drain
            c.idex_write  = 1'b1;
            c.exmem_write = 1'b1;
            c.idex_flush  = 1'b1;
        end else begin
            c.pc_write    = 1'b1;
            c.ifid_write  = 1'b1;
            c.idex_write  = 1'b1;
            c.exmem_write = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use, branch flush, memory wait states,
// memory watchdog and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_MemRead,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 idex_write,
    output logic                 exmem_write,
    output logic                 pc_src,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 memwb_flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int unsigned     WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    ctrl_t             ctrl;
    logic              load_use;
    logic              mem_stall;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_MemRead),
        .load_use    (load_use)
    );

    assign mem_stall = mem_req && !mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next state and per-cycle controls; everything is quiet while reset is held
    always_comb begin
        ctrl      = CTRL_IDLE;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        ctrl      = CTRL_MEM_STALL;
                        state_nxt = ST_MEM_WAIT;
                        wait_nxt  = WAIT_W'(1);
                    end else begin
                        ctrl = decode_run(branch_taken, load_use);
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        ctrl      = decode_run(branch_taken, load_use);
                        state_nxt = ST_RUN;
                        wait_nxt  = '0;
                    end else begin
                        // EX is frozen, so its branch/load-use terms are re-presented later
                        ctrl = CTRL_MEM_STALL;
                        if (wait_cnt == WAIT_LAST) begin
                            state_nxt = ST_HALT;
                        end else begin
                            wait_nxt = wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    ctrl = CTRL_IDLE;
                end
                default: begin
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                end
            endcase
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign idex_write  = ctrl.idex_write;
    assign exmem_write = ctrl.exmem_write;
    assign pc_src      = ctrl.pc_src;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign memwb_flush = ctrl.memwb_flush;
    assign halted      = (state == ST_HALT);

    // Saturating performance counters; halted cycles are not counted as stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctrl.pc_write && (state != ST_HALT) && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ctrl.pc_src && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: decode table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_CNT_W   = 4;
    localparam int          CMAX       = (1 << TB_CNT_W) - 1;

    // Output bundle order: pc_write ifid_write idex_write exmem_write pc_src ifid_flush idex_flush memwb_flush halted
    localparam logic [8:0] O_NORM  = 9'b111100000;
    localparam logic [8:0] O_LU    = 9'b001100100;
    localparam logic [8:0] O_BR    = 9'b111111100;
    localparam logic [8:0] O_MWAIT = 9'b000000010;
    localparam logic [8:0] O_HALT  = 9'b000000001;
    localparam logic [8:0] O_ZERO  = 9'b000000000;

    logic                clk = 1'b0;
    logic                reset;
    logic [4:0]          id_rs1, id_rs2, ex_rd;
    logic                id_uses_rs1, id_uses_rs2, ex_MemRead;
    logic                branch_taken, mem_req, mem_ready;
    logic                pc_write, ifid_write, idex_write, exmem_write;
    logic                pc_src, ifid_flush, idex_flush, memwb_flush, halted;
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]          dut_vec;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int         m_busy;
    bit         m_halted;
    bit         m_waiting;
    int         m_stall, m_flush;
    logic [8:0] m_exp;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       mr, bt, mq, mrdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_MemRead   (ex_MemRead),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_write   (idex_write),
        .exmem_write  (exmem_write),
        .pc_src       (pc_src),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .memwb_flush  (memwb_flush),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign dut_vec = {pc_write, ifid_write, idex_write, exmem_write,
                      pc_src, ifid_flush, idex_flush, memwb_flush, halted};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_MemRead = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Model: a memory access is outstanding while not ready; count consecutive misses
    task automatic model_eval();
        bit lu;
        lu = ex_MemRead && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        m_waiting = 1'b0;
        if (m_halted) begin
            m_exp = O_HALT;
        end else if (!mem_ready && (mem_req || m_busy > 0)) begin
            m_exp     = O_MWAIT;
            m_waiting = 1'b1;
        end else if (branch_taken) begin
            m_exp = O_BR;
        end else if (lu) begin
            m_exp = O_LU;
        end else begin
            m_exp = O_NORM;
        end
    endtask

    task automatic model_update();
        if (!m_exp[8] && !m_halted && m_stall < CMAX) m_stall++;
        if (m_exp[4] && m_flush < CMAX) m_flush++;
        if (!m_halted) begin
            if (m_waiting) begin
                m_busy++;
                if (m_busy >= TB_TIMEOUT) m_halted = 1'b1;
            end else begin
                m_busy = 0;
            end
        end
    endtask

    // Called one time unit after a posedge with inputs already applied
    task automatic settle();
        model_eval();
        @(negedge clk);
        check("model_ctrl", 32'(dut_vec), 32'(m_exp));
        check("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("model_flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_busy = 0; m_halted = 1'b0; m_stall = 0; m_flush = 0;
        check("reset_ctrl", 32'(dut_vec), 32'(O_ZERO));
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int halt_cycles;
        reset = 1'b1;
        clear_inputs();

        vecs[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[1]  = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[3]  = '{5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[4]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[5]  = '{5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[6]  = '{5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[7]  = '{5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[8]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[9]  = '{5'd4, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[10] = '{5'd4, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, O_NORM};

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single-cycle decode table, all in RUN
        for (int i = 0; i < 11; i++) begin
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_rd = vecs[i].rd; ex_MemRead = vecs[i].mr;
            branch_taken = vecs[i].bt; mem_req = vecs[i].mq; mem_ready = vecs[i].mrdy;
            settle();
            check($sformatf("table_%0d", i), 32'(dut_vec), 32'(vecs[i].exp));
            advance();
        end

        // Load-use costs one bubble, then decodes normally
        clear_inputs();
        do_reset();
        ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        settle();
        check("lu_out", 32'(dut_vec), 32'(O_LU));
        advance();
        ex_MemRead = 1'b0;
        settle();
        check("lu_next", 32'(dut_vec), 32'(O_NORM));
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        advance();

        // Branch beats a coincident load-use
        clear_inputs();
        do_reset();
        ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; branch_taken = 1'b1;
        settle();
        check("br_lu_out", 32'(dut_vec), 32'(O_BR));
        advance();
        clear_inputs();
        settle();
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd0);
        advance();

        // Memory ready after three wait cycles
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("mwait_out", 32'(dut_vec), 32'(O_MWAIT));
            advance();
        end
        mem_ready = 1'b1;
        settle();
        check("mwait_release", 32'(dut_vec), 32'(O_NORM));
        advance();
        clear_inputs();
        settle();
        check("mwait_stall_cnt", 32'(stall_cnt), 32'd3);
        advance();

        // Watchdog: never ready
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("timeout_wait", 32'(dut_vec), 32'(O_MWAIT));
            advance();
        end
        branch_taken = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("halt_out", 32'(dut_vec), 32'(O_HALT));
            advance();
        end
        check("halt_stall_cnt", 32'(stall_cnt), 32'd4);
        check("halt_flush_cnt", 32'(flush_cnt), 32'd0);
        clear_inputs();
        do_reset();
        check("halt_cleared", 32'(halted), 32'd0);

        // Reset while waiting on memory
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (2) begin
            settle();
            advance();
        end
        check("pre_reset_wait", 32'(dut_vec), 32'(O_MWAIT));
        do_reset();
        clear_inputs();
        settle();
        check("post_reset_run", 32'(dut_vec), 32'(O_NORM));
        advance();

        // Randomized traffic against the model
        halt_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0 || halt_cycles > 3) begin
                do_reset();
                halt_cycles = 0;
            end
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_uses_rs1  = ($urandom_range(0, 99) < 70);
            id_uses_rs2  = ($urandom_range(0, 99) < 50);
            ex_MemRead   = ($urandom_range(0, 99) < 40);
            branch_taken = ($urandom_range(0, 99) < 15);
            mem_req      = ($urandom_range(0, 99) < 25);
            mem_ready    = ($urandom_range(0, 99) < 55);
            settle();
            advance();
            if (m_halted) halt_cycles++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
